mole_keypad_frontend: RTL and testbench
=======================================

Name: mole_keypad_frontend

Overview:
- Input-side counterpart of the mole game's keypad consumer.
- Takes 8 raw, bouncy, asynchronous push-button lines and turns them into clean hits for the game core.
- Per key: synchronises, debounces and detects the press edge.
- Latches one one-hot hit that the game reads and releases with an acknowledge handshake, so no press is lost between slow game ticks. Also reports the debounced key levels and a count of dropped presses.

Parameters:
- N_KEYS, 8, number of keypad lines (one per mole hole).
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles needed to accept a level change (use 4 in simulation); must be >= 2.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; the only clock in the block.
- RESET  in  1  asynchronous, active-high reset.
- keypad  in  N_KEYS  raw button lines, active-high, asynchronous to clk.
- hit_ack  in  1  one-cycle pulse from the game core, synchronous to clk; releases the latched hit.
- key_level  out  N_KEYS  debounced level of each key.
- hit_valid  out  1  a latched hit is pending.
- hit_key  out  N_KEYS  one-hot latched key while hit_valid=1, else 0.
- hit_idx  out  3  binary index of hit_key; 0 when hit_valid=0.
- drop_cnt  out  8  saturating count of presses discarded because a hit was already pending or collided.

Behaviour:
- Reset (asynchronous, immediate): all synchroniser flops, stable levels and counters go to 0; key_level=0, hit_valid=0, hit_key=0, hit_idx=0, drop_cnt=0.
- Synchroniser: 2-flop chain per key. sync2 reflects a raw change 2 edges after it appears.
- Debounce, per key, evaluated on each edge:
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A raw change held long enough updates key_level on edge DEBOUNCE_CYCLES+2 after it appears.
  - A glitch that reverts before then resets cnt and never reaches key_level.
- Press event: a key's stable value goes 0->1 on this edge. Releases (1->0) update key_level only and generate no event.
- Hit latch, two states:
  - IDLE (hit_valid=0): on a press, load hit_key with the lowest-index pressing key and hit_idx with its index; go to PENDING on the same edge. Each additional simultaneous press increments drop_cnt.
  - PENDING (hit_valid=1): every new press increments drop_cnt; the first hit is kept.
  - hit_ack in PENDING: return to IDLE and clear hit_key/hit_idx.
  - hit_ack and a press on the same edge: the ack is applied first, then the press loads (new hit pending; that press is not counted as dropped).
  - hit_ack in IDLE: ignored.
- drop_cnt saturates at 255 and does not wrap. It is cleared only by RESET.
- Outputs are registered; no combinational path from keypad or hit_ack to any output.
- Holding a key down generates exactly one event. The next event for that key needs a debounced release followed by a debounced press.
- RESET mid-debounce or mid-PENDING: all progress is discarded. A key held through reset deassertion produces a press event once it has been debounced again.

Decomposition:
- Shared package holds:
  - N_KEYS and the default DEBOUNCE_CYCLES constants (board and simulation values).
  - The IDLE/PENDING state encoding.
  - A lowest-set-bit priority function returning the one-hot key and its index.
- One sub-module, key_debounce (synchroniser + counter + stable level + rise output), instantiated N_KEYS times with a generate loop.
- Top level holds the priority select, the hit latch state machine and drop_cnt.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: keypad=8'h04 held from edge 0 -> key_level[2]=1, hit_valid=1, hit_key=8'h04 and hit_idx=2 at edge 6; hit_ack pulse -> hit_valid=0 and hit_key=0 on the next edge.
- Bounce rejection: keypad[5] high for 3 cycles, low for 1, then high steadily -> no event until 6 edges after the last rise; exactly one hit with hit_idx=5; drop_cnt=0.
- Simultaneous press: keypad=8'h90 from edge 0 -> at edge 6, hit_key=8'h10, hit_idx=4, drop_cnt=1.
- Press while pending: hit on key 0 pending, key 3 pressed and debounced without ack -> hit_key stays 8'h01, drop_cnt increments to 1. Ack on the same edge that key 6 becomes debounced -> hit_key=8'h40, drop_cnt unchanged.
- Hold/release/saturation: hold key 1 for 100 cycles -> one event only. Then 300 dropped presses while a hit is pending -> drop_cnt=255.
- Async reset: assert RESET mid-PENDING, between clock edges -> all outputs 0 immediately. Key still held at reset deassertion -> new hit 6 edges later.

Source files
------------

// File: rtl/mole_keypad_frontend_pkg.sv
// Shared constants, hit-latch state encoding and key priority helper for the mole keypad frontend.
package mole_keypad_frontend_pkg;

  localparam int unsigned N_KEYS_DEF     = 8;
  localparam int unsigned IDX_W          = 3;
  localparam int unsigned DEBOUNCE_BOARD = 50000;
  localparam int unsigned DEBOUNCE_SIM   = 4;

  typedef enum logic [0:0] {
    StIdle,
    StPending
  } hit_state_e;

  typedef struct packed {
    logic [N_KEYS_DEF-1:0] onehot;
    logic [IDX_W-1:0]      idx;
  } key_sel_t;

  // Scans from the top down so the lowest set bit is the last one written.
  function automatic key_sel_t lowest_set(input logic [N_KEYS_DEF-1:0] v);
    key_sel_t s;
    s = '0;
    for (int i = N_KEYS_DEF - 1; i >= 0; i--) begin
      if (v[i]) begin
        s.onehot    = '0;
        s.onehot[i] = 1'b1;
        s.idx       = IDX_W'(i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/mole_keypad_frontend_key_debounce.sv
// One keypad line: 2-flop synchroniser, stability counter, debounced level and press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_done;

  assign w_done  = (r_sync2 != r_stable) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  // Rise is combinational so the hit latch loads on the same edge the level flips.
  assign o_rise  = w_done & r_sync2;
  assign o_level = r_stable;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mole_keypad_frontend.sv
// Keypad frontend: per-key debounce, lowest-index hit latch with ack handshake, dropped-press count.
module mole_keypad_frontend
  import mole_keypad_frontend_pkg::*;
#(
  parameter int unsigned N_KEYS          = N_KEYS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_BOARD,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_keypad,
  input  logic              i_hit_ack,
  output logic [N_KEYS-1:0] o_key_level,
  output logic              o_hit_valid,
  output logic [N_KEYS-1:0] o_hit_key,
  output logic [IDX_W-1:0]  o_hit_idx,
  output logic [7:0]        o_drop_cnt
);

  logic [N_KEYS-1:0] w_rise;
  key_sel_t          w_sel;
  logic [3:0]        w_npress;
  logic [3:0]        w_drops;
  logic [8:0]        w_sum;
  logic              w_load;

  hit_state_e        r_state;
  hit_state_e        w_state_next;
  logic [N_KEYS-1:0] r_hit_key;
  logic [N_KEYS-1:0] w_hit_key_next;
  logic [IDX_W-1:0]  r_hit_idx;
  logic [IDX_W-1:0]  w_hit_idx_next;
  logic [7:0]        r_drop_cnt;
  logic [7:0]        w_drop_cnt_next;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key_debounce (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_raw  (i_keypad[g]),
      .o_level(o_key_level[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_sel = lowest_set(w_rise);

  always_comb begin
    w_npress = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_npress = w_npress + 4'(w_rise[i]);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_hit_key_next = r_hit_key;
    w_hit_idx_next = r_hit_idx;
    w_drops        = '0;
    w_load         = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_load = (w_npress != 4'd0);
      end
      StPending: begin
        if (i_hit_ack) begin
          // Ack is applied first, so a same-edge press becomes the next hit.
          w_load         = (w_npress != 4'd0);
          w_state_next   = StIdle;
          w_hit_key_next = '0;
          w_hit_idx_next = '0;
        end else begin
          w_drops = w_npress;
        end
      end
      default: w_state_next = StIdle;
    endcase
    if (w_load) begin
      w_state_next   = StPending;
      w_hit_key_next = w_sel.onehot;
      w_hit_idx_next = w_sel.idx;
      w_drops        = w_npress - 4'd1;
    end
  end

  assign w_sum           = {1'b0, r_drop_cnt} + {5'b0, w_drops};
  assign w_drop_cnt_next = w_sum[8] ? 8'hFF : w_sum[7:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_hit_key  <= '0;
      r_hit_idx  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hit_key  <= w_hit_key_next;
      r_hit_idx  <= w_hit_idx_next;
      r_drop_cnt <= w_drop_cnt_next;
    end
  end

  assign o_hit_valid = (r_state == StPending);
  assign o_hit_key   = r_hit_key;
  assign o_hit_idx   = r_hit_idx;
  assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_mole_keypad_frontend.sv
// Directed bench for mole_keypad_frontend with a 4-cycle debounce window.
module tb_mole_keypad_frontend;

  logic       clk;
  logic       rst;
  logic [7:0] keypad;
  logic       hit_ack;
  logic [7:0] key_level;
  logic       hit_valid;
  logic [7:0] hit_key;
  logic [2:0] hit_idx;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  mole_keypad_frontend #(
    .N_KEYS         (8),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_keypad   (keypad),
    .i_hit_ack  (hit_ack),
    .o_key_level(key_level),
    .o_hit_valid(hit_valid),
    .o_hit_key  (hit_key),
    .o_hit_idx  (hit_idx),
    .o_drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    keypad  = '0;
    hit_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_ack();
    hit_ack = 1'b1;
    tick();
    hit_ack = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    keypad  = '0;
    hit_ack = 1'b0;
    tick();
    check("reset_level", key_level, 0);
    check("reset_valid", hit_valid, 0);
    check("reset_key", hit_key, 0);
    check("reset_idx", hit_idx, 0);
    check("reset_drop", drop_cnt, 0);

    // Clean press on key 2
    do_reset();
    keypad = 8'h04;
    repeat (5) tick();
    check("clean_e5_valid", hit_valid, 0);
    check("clean_e5_level", key_level, 0);
    tick();
    check("clean_e6_level", key_level, 8'h04);
    check("clean_e6_valid", hit_valid, 1);
    check("clean_e6_key", hit_key, 8'h04);
    check("clean_e6_idx", hit_idx, 2);
    pulse_ack();
    check("clean_ack_valid", hit_valid, 0);
    check("clean_ack_key", hit_key, 0);
    repeat (10) tick();
    check("clean_held_valid", hit_valid, 0);
    keypad = 8'h00;
    repeat (7) tick();
    check("clean_release_level", key_level, 0);
    pulse_ack();
    check("idle_ack_valid", hit_valid, 0);

    // Bounce on key 5: high 3, low 1, then high
    do_reset();
    keypad = 8'h20;
    repeat (3) tick();
    keypad = 8'h00;
    tick();
    keypad = 8'h20;
    repeat (5) tick();
    check("bounce_e9_valid", hit_valid, 0);
    check("bounce_e9_level", key_level, 0);
    tick();
    check("bounce_e10_valid", hit_valid, 1);
    check("bounce_e10_idx", hit_idx, 5);
    check("bounce_e10_key", hit_key, 8'h20);
    check("bounce_drop", drop_cnt, 0);

    // Simultaneous press of keys 4 and 7
    do_reset();
    keypad = 8'h90;
    repeat (6) tick();
    check("simul_level", key_level, 8'h90);
    check("simul_key", hit_key, 8'h10);
    check("simul_idx", hit_idx, 4);
    check("simul_drop", drop_cnt, 1);

    // Press while pending, then ack colliding with a new press
    do_reset();
    keypad = 8'h01;
    repeat (6) tick();
    check("pend_key0", hit_key, 8'h01);
    keypad = 8'h09;
    repeat (6) tick();
    check("pend_keep_key", hit_key, 8'h01);
    check("pend_drop", drop_cnt, 1);
    keypad = 8'h49;
    repeat (5) tick();
    check("pend_pre_ack_key", hit_key, 8'h01);
    pulse_ack();
    check("ackpress_valid", hit_valid, 1);
    check("ackpress_key", hit_key, 8'h40);
    check("ackpress_idx", hit_idx, 6);
    check("ackpress_drop", drop_cnt, 1);

    // Hold key 1 for a long time: one event only
    do_reset();
    keypad = 8'h02;
    repeat (6) tick();
    check("hold_key", hit_key, 8'h02);
    check("hold_idx", hit_idx, 1);
    pulse_ack();
    repeat (100) tick();
    check("hold_no_retrigger", hit_valid, 0);
    check("hold_drop", drop_cnt, 0);
    keypad = 8'h00;
    repeat (8) tick();

    // Saturation: key 0 pending, key 1 pressed 300 times
    keypad = 8'h01;
    repeat (6) tick();
    check("sat_pending_key", hit_key, 8'h01);
    for (int i = 0; i < 300; i++) begin
      keypad = 8'h03;
      repeat (7) tick();
      keypad = 8'h01;
      repeat (7) tick();
      if (i == 9) check("sat_drop_10", drop_cnt, 10);
      if (i == 254) check("sat_drop_255", drop_cnt, 255);
    end
    check("sat_drop_final", drop_cnt, 255);
    check("sat_key_kept", hit_key, 8'h01);

    // Asynchronous reset mid-pending, key 0 still held
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", hit_valid, 0);
    check("async_key", hit_key, 0);
    check("async_idx", hit_idx, 0);
    check("async_drop", drop_cnt, 0);
    check("async_level", key_level, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("post_rst_e5_valid", hit_valid, 0);
    tick();
    check("post_rst_e6_valid", hit_valid, 1);
    check("post_rst_e6_key", hit_key, 8'h01);
    check("post_rst_e6_drop", drop_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
